uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Buffered UART transmitter: the outbound counterpart to the UART receive path and RX FIFO. Producers (the CPU's memory-mapped I/O store path, or a debug dumper) push bytes into a 16-entry FIFO. An 8N1 serializer drains the FIFO onto the physical TX pin at a fixed baud rate, sending frames back-to-back. It runs entirely in the CPU clock domain and drives `_20a` at the top level.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200 baud, truncated); legal range 2..65535.
- `DEPTH`, default 16: FIFO entries; must be a power of two, 2..256.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `wr_en` input 1: push request for `wr_data`.
- `wr_data` input 8: byte to enqueue.
- `clr_overflow` input 1: synchronous clear of `overflow`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is on the line (START/DATA/STOP).
- `tx_done` output 1: one-cycle pulse at the end of each stop bit.
- `fifo_full` output 1: count == DEPTH.
- `fifo_empty` output 1: count == 0.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set when a push is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, FSM=IDLE, pointers=0.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count.
  - Push is accepted iff `wr_en` && (!full || pop in the same cycle).
  - A rejected push sets `overflow`. FIFO contents and count are unchanged.
  - Pop only when count > 0 before the edge. There is no write-to-read bypass, so a byte written into an empty FIFO cannot pop in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- `overflow`: `clr_overflow` clears it. If a clear and a drop occur in the same cycle, the drop wins and `overflow` stays 1.
- Serializer FSM, with baud counter `bcnt` (0..CLKS_PER_BIT-1) and bit index `bidx` (0..7):
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear `bcnt`, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bidx`=0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right and `bidx` increments. After `bidx`=7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `tx` is registered, so it is glitch-free.
- `busy` is registered and equals (state != IDLE).
- Reset asserted mid-frame: `tx` returns high immediately (asynchronously) and all queued bytes are discarded.

## Timing
- Push latency: push sampled at edge N gives `fifo_empty`=0 and `fifo_count`=1 after edge N.
- Start latency: if the FSM is IDLE, it pops at edge N+1, and `tx`=0 and `busy`=1 after edge N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- `tx_done` is high for the single cycle that ends the stop bit. The next start bit, if any, begins on the following edge.
- Back-to-back frames: a FIFO of K bytes drains in exactly 10×K×CLKS_PER_BIT cycles, measured from the first start bit.
- `fifo_count` decrements on the edge of each pop: the IDLE→START or STOP→START transition.

## Test plan
- Single byte, CLKS_PER_BIT=4. Push 0xA5 at edge N:
  - `tx` goes low after edge N+1.
  - Line samples every 4 cycles read 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` pulses after 40 cycles; `busy` drops on the next edge.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles.
  - 120 contiguous bit-cycles with no idle between stop and start.
  - Exactly three `tx_done` pulses, 40 cycles apart.
- Full/overflow, DEPTH=16, TX stalled by holding `reset` until the pushes begin:
  - Push 18 bytes in 18 cycles. First byte pops at cycle 2, so 17 are accepted and the 18th is dropped.
  - `fifo_full`=1 and `overflow`=1.
  - `clr_overflow` clears `overflow`. The line emits the 17 accepted bytes in order.
- Push while full, coinciding with a pop at STOP→START:
  - The push is accepted, count stays 16, `overflow` stays 0.
- Pointer wrap-around: stream 40 bytes (0x00..0x27) while keeping occupancy between 1 and 15.
  - Received sequence matches exactly, with no duplicates or drops.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - `tx`=1, `busy`=0, `fifo_count`=0 with no clock edge.
  - After release, a new push of 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a serializer
// that sends frames back-to-back at CLKS_PER_BIT clocks per bit.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_overflow,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] BCNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        bcnt_q, bcnt_d;
    logic [2:0]         bidx_q, bidx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               tx_done_q, tx_done_d;

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;

    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               bit_end_s;

    assign bit_end_s = (bcnt_q == BCNT_LAST);

    // Serializer next state; pops happen only on IDLE->START and STOP->START.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rptr_q];
                    bcnt_d  = 16'd0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    bcnt_d  = 16'd0;
                    bidx_d  = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    bcnt_d = 16'd0;
                    if (bidx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    bcnt_d = 16'd0;
                    if (count_q != {CNT_W{1'b0}}) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bcnt_d  = 16'd0;
            end
        endcase
    end

    // Line outputs are derived from the next state so they register cleanly.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d    = (state_d != ST_IDLE);
        tx_done_d = (state_d == ST_STOP) && (bcnt_d == BCNT_LAST);
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        push_s  = wr_en && (!full_q || pop_s);
        drop_s  = wr_en && !push_s;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == {CNT_W{1'b0}});
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= 16'd0;
            bidx_q     <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            wptr_q     <= {PTR_W{1'b0}};
            rptr_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            bidx_q     <= bidx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; stale contents are harmless because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: bytes pushed into a scoreboard queue are
// checked against frames decoded from the tx line by a concurrent monitor.
module tb_uart_tx_stream;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         rx_count = 0;
    bit         abort = 1'b0;
    logic [7:0] exp_q [$];

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || fifo_empty !== 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_bound", 32'(n < 5000), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    // Line monitor: decodes each frame at mid-bit and checks it against the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic       start_ok, stop_ok, busy_ok, done_ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                @(negedge clk);
                start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_ok = (tx === 1'b1);
                busy_ok = (busy === 1'b1);
                repeat (CPB - 2) @(negedge clk);
                done_ok = (tx_done === 1'b1) && (tx === 1'b1);
                if (abort) begin
                    abort = 1'b0;
                end else begin
                    rx_count++;
                    chk("rx_start_bit", 32'(start_ok), 32'd1);
                    chk("rx_stop_bit", 32'(stop_ok), 32'd1);
                    chk("rx_busy_in_frame", 32'(busy_ok), 32'd1);
                    chk("rx_tx_done_at_stop_end", 32'(done_ok), 32'd1);
                    chk("rx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    chk("rx_byte", 32'(b), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int done_idx [$];
        int busy_low;
        int to;

        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte: push latency, start latency, frame length.
        push(8'hA5, 1'b1);
        chk("push_count", 32'(fifo_count), 32'd1);
        chk("push_empty", 32'(fifo_empty), 32'd0);
        chk("push_tx_idle", 32'(tx), 32'd1);
        @(negedge clk);
        chk("start_tx_low", 32'(tx), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_popped", 32'(fifo_count), 32'd0);
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len_to_done", 32'(n), 32'd39);
        @(negedge clk);
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_pulse", 32'(tx_done), 32'd0);
        chk("after_done_tx", 32'(tx), 32'd1);
        wait_idle();

        // Back-to-back frames, no idle gap.
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h55, 1'b1);
        busy_low = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done_idx.size() < 3 && busy !== 1'b1) busy_low++;
            if (tx_done === 1'b1) done_idx.push_back(i);
        end
        chk("b2b_done_pulses", 32'(done_idx.size()), 32'd3);
        if (done_idx.size() == 3) begin
            chk("b2b_first_done", 32'(done_idx[0]), 32'd38);
            chk("b2b_gap1", 32'(done_idx[1] - done_idx[0]), 32'd40);
            chk("b2b_gap2", 32'(done_idx[2] - done_idx[1]), 32'd40);
        end
        chk("b2b_busy_gaps", 32'(busy_low), 32'd0);
        wait_idle();

        // Full / overflow: 18 pushes in 18 cycles right out of reset.
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 18; k++) begin
            reset = 1'b0;
            push(8'(8'h80 + k), k < 17);
        end
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_flag", 32'(fifo_full), 32'd1);
        chk("full_overflow", 32'(overflow), 32'd1);
        wr_en        = 1'b1;
        wr_data      = 8'hEE;
        clr_overflow = 1'b1;
        @(negedge clk);
        wr_en        = 1'b0;
        chk("drop_beats_clear", 32'(overflow), 32'd1);
        chk("drop_count_kept", 32'(fifo_count), 32'd16);
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("clear_overflow", 32'(overflow), 32'd0);

        // Push while full, landing on the STOP->START pop.
        n = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stop_wait_bound", 32'(n < 200), 32'd1);
        chk("full_before_pop", 32'(fifo_count), 32'd16);
        push(8'h99, 1'b1);
        chk("pop_push_count", 32'(fifo_count), 32'd16);
        chk("pop_push_full", 32'(fifo_full), 32'd1);
        chk("pop_push_no_overflow", 32'(overflow), 32'd0);
        wait_idle();

        // Pointer wrap-around: 40 bytes with bounded occupancy.
        to = 0;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (fifo_count >= 5'd8 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 1000) to++;
            push(8'(i), 1'b1);
        end
        chk("wrap_wait_bound", 32'(to), 32'd0);
        wait_idle();

        // Reset during DATA bit 3 with more bytes queued.
        push(8'h5A, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        repeat (16) @(negedge clk);
        #1;
        reset = 1'b1;
        abort = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_empty", 32'(fifo_empty), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        push(8'h3C, 1'b1);
        chk("post_rst_push_count", 32'(fifo_count), 32'd1);
        wait_idle();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("rx_frames", 32'(rx_count), 32'd63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
